// File: rtl/io_trace_if.sv
// Event stream port of the trace monitor: one {ch, stamp, data} record per
// accepted transfer, valid/ready handshake.
interface io_trace_if #(
  parameter int CHW = 2,
  parameter int TSW = 32,
  parameter int DW  = 32
) ();
  logic           o_evt_valid;
  logic           i_evt_ready;
  logic [CHW-1:0] o_evt_ch;
  logic [TSW-1:0] o_evt_stamp;
  logic [DW-1:0]  o_evt_data;

  modport master (
    output o_evt_valid,
    output o_evt_ch,
    output o_evt_stamp,
    output o_evt_data,
    input  i_evt_ready
  );

  modport slave (
    input  o_evt_valid,
    input  o_evt_ch,
    input  o_evt_stamp,
    input  o_evt_data,
    output i_evt_ready
  );
endinterface

// File: rtl/io_trace_monitor.sv
// Event-trace monitor: stamps every change of NCH packed channels with the
// enabled-cycle count and queues it in a FIFO drained over a valid/ready port.
// Also counts retired instructions and flags a stalled PC (sticky).
module io_trace_monitor #(
  parameter int NCH   = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 16,
  parameter int TSW   = 32,
  parameter int HANG  = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_en,
  input  logic [NCH*DW-1:0]   i_ch_data,
  input  logic [31:0]         i_pc,
  input  logic                i_insn_vld,
  io_trace_if.master          evt,
  output logic                o_overflow,
  output logic [31:0]         o_retired,
  output logic                o_hang,
  output logic [TSW-1:0]      o_cycle
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int HCW = $clog2(HANG);

  // Change-detect state and per-channel pending slots
  logic [DW-1:0]  r_shadow     [NCH];
  logic [DW-1:0]  r_slot_data  [NCH];
  logic [TSW-1:0] r_slot_stamp [NCH];
  logic [NCH-1:0] r_pend;

  // Event FIFO
  logic [CHW-1:0] r_mem_ch    [DEPTH];
  logic [TSW-1:0] r_mem_stamp [DEPTH];
  logic [DW-1:0]  r_mem_data  [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [AW:0]    r_count;

  // Counters and hang detection
  logic [TSW-1:0] r_cycle;
  logic [31:0]    r_retired;
  logic [31:0]    r_pc_prev;
  logic [HCW-1:0] r_stall;
  logic           r_hang;
  logic           r_overflow;

  logic [NCH-1:0] w_change;
  logic [NCH-1:0] w_grant;
  logic [CHW-1:0] w_sel;
  logic           w_any;
  logic           w_valid;
  logic           w_full;
  logic           w_pop;
  logic           w_push;

  // Per-channel change strobe, only while monitoring is enabled
  always_comb begin
    w_change = '0;
    for (int k = 0; k < NCH; k++) begin
      w_change[k] = i_en && (i_ch_data[k*DW +: DW] != r_shadow[k]);
    end
  end

  // Fixed-priority arbiter: lowest-index pending channel wins the push slot
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_any = 1'b1;
        w_sel = CHW'(k);
      end
    end
  end

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_pop   = w_valid && evt.i_evt_ready;
  // A full FIFO still accepts a push when the head leaves on the same edge
  assign w_push  = w_any && (!w_full || w_pop);

  // One-hot grant, used to tell "being queued now" apart from a true overwrite
  always_comb begin
    w_grant = '0;
    if (w_push) begin
      w_grant = NCH'(1) << w_sel;
    end
  end

  // Stage 0 -> 1: shadow update and pending-slot capture
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend     <= '0;
      r_overflow <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        r_shadow[k]     <= '0;
        r_slot_data[k]  <= '0;
        r_slot_stamp[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (i_en) begin
          r_shadow[k] <= i_ch_data[k*DW +: DW];
        end
        if (w_change[k]) begin
          r_slot_data[k]  <= i_ch_data[k*DW +: DW];
          r_slot_stamp[k] <= r_cycle;
          r_pend[k]       <= 1'b1;
          if (r_pend[k] && !w_grant[k]) begin
            r_overflow <= 1'b1;
          end
        end else if (w_grant[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  // Stage 1 -> 2: FIFO pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents only matter while counted, so no reset needed
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_ch[r_wr_ptr]    <= w_sel;
      r_mem_stamp[r_wr_ptr] <= r_slot_stamp[w_sel];
      r_mem_data[r_wr_ptr]  <= r_slot_data[w_sel];
    end
  end

  // Cycle, retired-instruction and PC-stall counters, frozen while disabled
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle   <= '0;
      r_retired <= '0;
      r_pc_prev <= '0;
      r_stall   <= '0;
      r_hang    <= 1'b0;
    end else if (i_en) begin
      r_cycle   <= r_cycle + 1'b1;
      r_pc_prev <= i_pc;
      if (i_insn_vld) begin
        r_retired <= r_retired + 1'b1;
      end
      if (i_pc == r_pc_prev) begin
        // Counter saturates at HANG-1; the HANG-th stalled edge sets the flag
        if (r_stall == HCW'(HANG - 1)) begin
          r_hang <= 1'b1;
        end else begin
          r_stall <= r_stall + 1'b1;
        end
      end else begin
        r_stall <= '0;
      end
    end
  end

  // Head fields are forced to zero when empty so reset drives all outputs low
  assign evt.o_evt_valid = w_valid;
  assign evt.o_evt_ch    = w_valid ? r_mem_ch[r_rd_ptr]    : '0;
  assign evt.o_evt_stamp = w_valid ? r_mem_stamp[r_rd_ptr] : '0;
  assign evt.o_evt_data  = w_valid ? r_mem_data[r_rd_ptr]  : '0;

  assign o_overflow = r_overflow;
  assign o_retired  = r_retired;
  assign o_hang     = r_hang;
  assign o_cycle    = r_cycle;

endmodule

// File: tb/tb_io_trace_monitor.sv
// Directed bench for io_trace_monitor (NCH=4, DW=32, DEPTH=16, HANG=8).
module tb_io_trace_monitor;

  localparam int NCH   = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int TSW   = 32;
  localparam int HANG  = 8;
  localparam int CHW   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              insn_vld = 1'b0;
  logic              ready = 1'b1;
  logic              pc_run = 1'b0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [31:0]       pc = '0;
  logic              overflow;
  logic              hang;
  logic [31:0]       retired;
  logic [TSW-1:0]    cycle;

  int total = 0;
  int fails = 0;
  int n;

  io_trace_if #(.CHW(CHW), .TSW(TSW), .DW(DW)) evt_if ();
  assign evt_if.i_evt_ready = ready;

  io_trace_monitor #(
    .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .TSW(TSW), .HANG(HANG)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_en       (en),
    .i_ch_data  (ch_data),
    .i_pc       (pc),
    .i_insn_vld (insn_vld),
    .evt        (evt_if),
    .o_overflow (overflow),
    .o_retired  (retired),
    .o_hang     (hang),
    .o_cycle    (cycle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (pc_run) pc = pc + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", evt_if.o_evt_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_hang", hang, 0);
    chk("rst_retired", retired, 0);
    chk("rst_cycle", cycle, 0);
    chk("rst_ch", evt_if.o_evt_ch, 0);
    chk("rst_stamp", evt_if.o_evt_stamp, 0);
    chk("rst_data", evt_if.o_evt_data, 0);
    rst_n = 1'b1;
    en = 1'b1;
    pc_run = 1'b1;

    // Single change on channel 2 at cycle 10
    repeat (10) tick();
    chk("cycle10", cycle, 10);
    ch_data[2*DW +: DW] = 32'h5;
    tick();
    chk("t1_cycle11", cycle, 11);
    chk("t1_not_yet", evt_if.o_evt_valid, 0);
    tick();
    chk("t1_valid", evt_if.o_evt_valid, 1);
    chk("t1_ch", evt_if.o_evt_ch, 2);
    chk("t1_stamp", evt_if.o_evt_stamp, 10);
    chk("t1_data", evt_if.o_evt_data, 32'h5);
    tick();
    chk("t1_popped", evt_if.o_evt_valid, 0);
    repeat (3) tick();
    chk("t1_quiet", evt_if.o_evt_valid, 0);

    // Channels 0, 1, 3 change together at cycle 16
    ch_data[0*DW +: DW] = 32'h11;
    ch_data[1*DW +: DW] = 32'h22;
    ch_data[3*DW +: DW] = 32'h33;
    tick();
    chk("t2_not_yet", evt_if.o_evt_valid, 0);
    tick();
    chk("t2_e0_ch", evt_if.o_evt_ch, 0);
    chk("t2_e0_stamp", evt_if.o_evt_stamp, 16);
    chk("t2_e0_data", evt_if.o_evt_data, 32'h11);
    tick();
    chk("t2_e1_ch", evt_if.o_evt_ch, 1);
    chk("t2_e1_stamp", evt_if.o_evt_stamp, 16);
    chk("t2_e1_data", evt_if.o_evt_data, 32'h22);
    tick();
    chk("t2_e2_ch", evt_if.o_evt_ch, 3);
    chk("t2_e2_stamp", evt_if.o_evt_stamp, 16);
    chk("t2_e2_data", evt_if.o_evt_data, 32'h33);
    tick();
    chk("t2_empty", evt_if.o_evt_valid, 0);
    chk("t2_cycle", cycle, 21);

    // Back-pressure: 20 changes on channel 1, FIFO fills, pending overwritten
    ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      ch_data[1*DW +: DW] = 32'h100 + i;
      tick();
      tick();
      if (i == 17) chk("t3_ovf_before", overflow, 0);
      if (i == 18) chk("t3_ovf_after", overflow, 1);
    end
    chk("t3_ovf", overflow, 1);
    chk("t3_valid", evt_if.o_evt_valid, 1);
    chk("t3_head_ch", evt_if.o_evt_ch, 1);
    chk("t3_head_stamp", evt_if.o_evt_stamp, 21);
    chk("t3_head_data", evt_if.o_evt_data, 32'h101);

    // Release: first edge pops and pushes at full, then 17 events drain in order
    ready = 1'b1;
    n = 0;
    for (int b = 0; b < 40; b++) begin
      if (!evt_if.o_evt_valid) break;
      chk("t4_drain_data", evt_if.o_evt_data, (n < 16) ? (32'h101 + n) : 32'h114);
      n++;
      tick();
    end
    chk("t4_drain_count", n, 17);
    chk("t4_empty", evt_if.o_evt_valid, 0);
    chk("t4_ovf_sticky", overflow, 1);
    chk("t4_cycle", cycle, 78);

    // Disabled: no detection, counters frozen
    en = 1'b0;
    insn_vld = 1'b1;
    ch_data[0*DW +: DW] = 32'hAA;
    repeat (3) tick();
    chk("en0_cycle", cycle, 78);
    chk("en0_retired", retired, 0);
    chk("en0_no_evt", evt_if.o_evt_valid, 0);
    insn_vld = 1'b0;
    ch_data[0*DW +: DW] = 32'h11;
    en = 1'b1;

    // Hang: PC held at 0x40 for 8 stalled edges
    pc_run = 1'b0;
    pc = 32'h40;
    tick();
    repeat (HANG - 1) tick();
    chk("hang_7", hang, 0);
    tick();
    chk("hang_8", hang, 1);
    pc_run = 1'b1;
    repeat (2) tick();
    chk("hang_sticky", hang, 1);

    // Retired: 5 pulses
    for (int i = 0; i < 5; i++) begin
      insn_vld = 1'b1;
      tick();
      insn_vld = 1'b0;
      tick();
    end
    chk("retired5", retired, 5);

    // Reset mid-drain with 6 queued
    ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ch_data[0*DW +: DW] = 32'h200 + i;
      tick();
      tick();
    end
    chk("t6_queued", evt_if.o_evt_valid, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", evt_if.o_evt_valid, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_hang", hang, 0);
    chk("t6_rst_retired", retired, 0);
    chk("t6_rst_cycle", cycle, 0);
    ch_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    repeat (4) tick();
    chk("t6_no_evt", evt_if.o_evt_valid, 0);
    chk("t6_cycle", cycle, 4);
    ch_data[3*DW +: DW] = 32'h77;
    tick();
    tick();
    chk("t6_new_valid", evt_if.o_evt_valid, 1);
    chk("t6_new_ch", evt_if.o_evt_ch, 3);
    chk("t6_new_stamp", evt_if.o_evt_stamp, 4);
    chk("t6_new_data", evt_if.o_evt_data, 32'h77);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  // Watchdog against a stuck run
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
